// File: rtl/c_merge_n_d_arb.sv
// N-input merge with data: arbitrates pending one-cycle drives, registers the winner's data
// and handshakes downstream. Define CMERGE_RR_ARB_EN for round-robin, else fixed priority.
module c_merge_n_d_arb #(
    parameter  int DATA_WIDTH = 128,
    parameter  int NUM_CH     = 4,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            i_drive,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_free,
    output logic                         o_driveNext,
    input  logic                         i_freeNext,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [CH_W-1:0]              o_grant,
    output logic                         o_busy,
    output logic [NUM_CH-1:0]            o_overrun
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CH-1:0]       pend_q, pend_d;
    logic [NUM_CH-1:0]       free_q, free_d;
    logic [NUM_CH-1:0]       ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CH_W-1:0]         grant_q, grant_d;
    logic                    dn_q, dn_d;

    logic                    win_found;
    logic [CH_W-1:0]         win_idx;
    logic [NUM_CH-1:0]       clear_mask;
    logic [NUM_CH-1:0]       busy_mask;
    logic [NUM_CH-1:0]       drop;

`ifdef CMERGE_RR_ARB_EN
    logic [CH_W-1:0]         ptr_q, ptr_d;
    logic [CH_W-1:0]         cand;

    // Search starts just past the last granted channel and wraps.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int unsigned'(ptr_q) + 1 + i) % NUM_CH);
            if (!win_found && pend_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!win_found && pend_q[CH_W'(i)]) begin
                win_found = 1'b1;
                win_idx   = CH_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        grant_d    = grant_q;
        dn_d       = 1'b0;
        free_d     = '0;
        clear_mask = '0;
`ifdef CMERGE_RR_ARB_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    data_d     = i_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    grant_d    = win_idx;
                    clear_mask = NUM_CH'(1) << win_idx;
                    dn_d       = 1'b1;
                    state_d    = S_WAIT;
`ifdef CMERGE_RR_ARB_EN
                    ptr_d      = win_idx;
`endif
                end
            end
            S_WAIT: begin
                if (i_freeNext) begin
                    free_d  = NUM_CH'(1) << grant_q;
                    state_d = S_IDLE;
                end
            end
        endcase

        // A drive is lost if its channel already waits, unless that wait is being granted
        // on this very edge; the channel currently held in WAIT cannot queue another.
        busy_mask = (state_q == S_WAIT) ? (NUM_CH'(1) << grant_q) : '0;
        drop      = i_drive & ((pend_q & ~clear_mask) | busy_mask);
        pend_d    = (pend_q & ~clear_mask) | (i_drive & ~drop);
        ovr_d     = drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            free_q  <= '0;
            ovr_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
            dn_q    <= 1'b0;
`ifdef CMERGE_RR_ARB_EN
            ptr_q   <= CH_W'(NUM_CH - 1);
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            free_q  <= free_d;
            ovr_q   <= ovr_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            dn_q    <= dn_d;
`ifdef CMERGE_RR_ARB_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign o_free      = free_q;
    assign o_driveNext = dn_q;
    assign o_data      = data_q;
    assign o_grant     = grant_q;
    assign o_busy      = (state_q == S_WAIT);
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_c_merge_n_d_arb.sv
// Scoreboard bench for c_merge_n_d_arb: a transaction-level model predicts grants, frees and
// overruns into queues; a monitor compares them against the DUT one step after each clock edge.
module tb_c_merge_n_d_arb;

    localparam int DW = 128;
    localparam int N  = 4;
    localparam int CW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    i_drive = '0;
    logic [N*DW-1:0] i_data = '0;
    logic            i_freeNext = 1'b0;
    logic [N-1:0]    o_free;
    logic            o_driveNext;
    logic [DW-1:0]   o_data;
    logic [CW-1:0]   o_grant;
    logic            o_busy;
    logic [N-1:0]    o_overrun;

    c_merge_n_d_arb #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .o_free      (o_free),
        .o_driveNext (o_driveNext),
        .i_freeNext  (i_freeNext),
        .o_data      (o_data),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct { int unsigned cyc; int g; logic [DW-1:0] d; } dn_t;
    typedef struct { int unsigned cyc; logic [N-1:0] m; } mk_t;
    dn_t dq[$];
    mk_t fq[$];
    mk_t oq[$];

    // Reference model: which channels wait, whether one is outstanding, last grant.
    bit            m_pend[N];
    bit            m_wait;
    int            m_g;
    int            m_ptr;
    logic [DW-1:0] ch_data[N];

    int dn_cnt = 0;
    int free_cnt[N];
    int ov_cnt[N];
    int gq[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pick();
`ifdef CMERGE_RR_ARB_EN
        for (int k = m_ptr + 1; k < N; k++) if (m_pend[k]) return k;
`endif
        for (int k = 0; k < N; k++) if (m_pend[k]) return k;
        return -1;
    endfunction

    function automatic bit held(input int k);
        return m_pend[k] || (m_wait && m_g == k);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
        m_wait = 1'b0;
        m_g    = 0;
        m_ptr  = N - 1;
    endtask

    task automatic model_edge(input logic [N-1:0] drv, input logic fn);
        int           win;
        logic [N-1:0] ovm;
        win = m_wait ? -1 : pick();
        ovm = '0;
        for (int k = 0; k < N; k++)
            if (drv[k] && ((m_pend[k] && k != win) || (m_wait && m_g == k))) ovm[k] = 1'b1;
        if (ovm != '0) oq.push_back('{cyc + 1, ovm});
        if (win >= 0) begin
            dq.push_back('{cyc + 1, win, ch_data[win]});
            m_pend[win] = 1'b0;
            m_g         = win;
            m_ptr       = win;
            m_wait      = 1'b1;
        end else if (m_wait && fn) begin
            fq.push_back('{cyc + 1, N'(1) << m_g});
            m_wait = 1'b0;
        end
        for (int k = 0; k < N; k++) if (drv[k] && !ovm[k]) m_pend[k] = 1'b1;
    endtask

    task automatic step(input logic [N-1:0] drv, input logic fn, input logic r);
        @(negedge clk);
        i_drive    = drv;
        i_freeNext = fn;
        rst        = r;
        for (int k = 0; k < N; k++) i_data[k*DW +: DW] = ch_data[k];
        if (r) model_reset();
        else   model_edge(drv, fn);
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 1'b0, 1'b0);
    endtask

    // Returns each observed grant immediately; bounded by a cycle budget.
    task automatic collect(input int want);
        logic fn;
        gq.delete();
        for (int c = 0; c < 40 && gq.size() < want; c++) begin
            @(posedge clk); #1;
            fn = o_driveNext;
            if (o_driveNext) gq.push_back(int'(o_grant));
            step('0, fn, 1'b0);
        end
    endtask

    task automatic monitor_cycle();
        bit           exp_dn;
        logic [N-1:0] exp_m;
        exp_dn = (dq.size() > 0 && dq[0].cyc == cyc);
        if (exp_dn || o_driveNext) begin
            chk("driveNext", 128'(o_driveNext), 128'(exp_dn));
            if (exp_dn && o_driveNext) begin
                chk("grant", 128'(o_grant), 128'(dq[0].g));
                chk("data", 128'(o_data), 128'(dq[0].d));
            end
            if (exp_dn) void'(dq.pop_front());
        end
        exp_m = (fq.size() > 0 && fq[0].cyc == cyc) ? fq[0].m : '0;
        if (exp_m != '0) void'(fq.pop_front());
        if (exp_m != '0 || o_free != '0) chk("free", 128'(o_free), 128'(exp_m));
        exp_m = (oq.size() > 0 && oq[0].cyc == cyc) ? oq[0].m : '0;
        if (exp_m != '0) void'(oq.pop_front());
        if (exp_m != '0 || o_overrun != '0) chk("overrun", 128'(o_overrun), 128'(exp_m));
        chk("busy", 128'(o_busy), 128'(m_wait));
        if (o_driveNext) dn_cnt++;
        for (int k = 0; k < N; k++) begin
            if (o_free[k]) free_cnt[k]++;
            if (o_overrun[k]) ov_cnt[k]++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (mon_en) monitor_cycle();
        end
    end

    initial begin
        int ov0, fr0, d0;
        logic [N-1:0] drv;
        logic fn;
        for (int k = 0; k < N; k++) begin
            ch_data[k]  = '0;
            free_cnt[k] = 0;
            ov_cnt[k]   = 0;
        end
        model_reset();

        // Reset state
        step('0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("rst_driveNext", 128'(o_driveNext), 128'(0));
        chk("rst_free", 128'(o_free), 128'(0));
        chk("rst_data", 128'(o_data), 128'(0));
        chk("rst_grant", 128'(o_grant), 128'(0));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_overrun", 128'(o_overrun), 128'(0));
        mon_en = 1'b1;
        idle(2);

        // Single request on ch2
        ch_data[2] = DW'(8'hA5);
        step(4'b0100, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("single_driveNext", 128'(o_driveNext), 128'(1));
        chk("single_data", 128'(o_data), 128'(8'hA5));
        chk("single_grant", 128'(o_grant), 128'(2));
        chk("single_busy", 128'(o_busy), 128'(1));
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("single_free", 128'(o_free), 128'(4'b0100));
        chk("single_busy_after", 128'(o_busy), 128'(0));
        idle(2);

        // All four at once, then ch0 and ch3
        for (int k = 0; k < N; k++) ch_data[k] = rand_data();
        step(4'b1111, 1'b0, 1'b0);
        collect(4);
        chk("all4_count", 128'(gq.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("all4_grant%0d", i), 128'(i < gq.size() ? gq[i] : -1), 128'(i));
        ch_data[0] = rand_data();
        ch_data[3] = rand_data();
        step(4'b1001, 1'b0, 1'b0);
        collect(2);
        chk("pair_count", 128'(gq.size()), 128'(2));
        chk("pair_first", 128'(gq.size() > 0 ? gq[0] : -1), 128'(0));
        chk("pair_second", 128'(gq.size() > 1 ? gq[1] : -1), 128'(3));
        idle(2);

        // Overrun on ch1 while ch0 is held in WAIT
        ov0 = ov_cnt[1];
        fr0 = free_cnt[1];
        ch_data[0] = rand_data();
        ch_data[1] = rand_data();
        step(4'b0001, 1'b0, 1'b0);
        idle(2);
        step(4'b0010, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        idle(2);
        step('0, 1'b1, 1'b0);
        collect(1);
        idle(3);
        chk("ovr_grant", 128'(gq.size() > 0 ? gq[0] : -1), 128'(1));
        chk("ovr_pulses", 128'(ov_cnt[1] - ov0), 128'(1));
        chk("ovr_ch1_frees", 128'(free_cnt[1] - fr0), 128'(1));

        // Spurious free in IDLE
        step('0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("spur_free", 128'(o_free), 128'(0));
        chk("spur_busy", 128'(o_busy), 128'(0));
        chk("spur_driveNext", 128'(o_driveNext), 128'(0));
        idle(2);

        // Data persistence
        ch_data[1] = DW'(16'h1234);
        step(4'b0010, 1'b0, 1'b0);
        collect(1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("persist_data", 128'(o_data), 128'(16'h1234));
            step('0, 1'b0, 1'b0);
        end
        chk("persist_grant", 128'(o_grant), 128'(1));

        // Reset while in WAIT
        ch_data[3] = rand_data();
        step(4'b1000, 1'b0, 1'b0);
        idle(2);
        step('0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("mrst_driveNext", 128'(o_driveNext), 128'(0));
        chk("mrst_free", 128'(o_free), 128'(0));
        chk("mrst_data", 128'(o_data), 128'(0));
        chk("mrst_grant", 128'(o_grant), 128'(0));
        chk("mrst_busy", 128'(o_busy), 128'(0));
        chk("mrst_overrun", 128'(o_overrun), 128'(0));
        step('0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("mrst_late_free", 128'(o_free), 128'(0));
        d0 = dn_cnt;
        idle(6);
        chk("mrst_no_grant", 128'(dn_cnt - d0), 128'(0));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            drv = '0;
            for (int k = 0; k < N; k++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (!held(k)) begin
                    if (r < 25) begin
                        ch_data[k] = rand_data();
                        drv[k]     = 1'b1;
                    end
                end else if (r < 5) begin
                    drv[k] = 1'b1;
                end
            end
            fn = ($urandom_range(0, 99) < 40);
            step(drv, fn, 1'b0);
        end
        repeat (12) step('0, 1'b1, 1'b0);
        idle(3);
        chk("sb_empty", 128'(dq.size() + fq.size() + oq.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
